// File: rtl/intpol2_d4_in_feeder_pkg.sv
// -----------------------------------------------------------------------------
// intpol2_d4_in_feeder_pkg
//   Shared definitions for the interpolator input-FIFO feeder. The state
//   encoding is common with the interpolator control-path FSMs so that all
//   of them read the same way in waveforms and debug registers.
// -----------------------------------------------------------------------------
package intpol2_d4_in_feeder_pkg;

  // Transfer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

  // Default geometry: 32-bit samples, 128-entry sample memory
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_SIZE_Y = 7;

endpackage

// File: rtl/intpol2_d4_in_feeder_skid1.sv
// -----------------------------------------------------------------------------
// intpol2_d4_in_feeder_skid1
//   One-entry hold register. Catches a memory sample that arrives while the
//   FIFO reports almost-full, and releases it once the FIFO has room.
//
// Ports
//   clk          in   clock, rising edge
//   rstn         in   asynchronous active-low reset (clears valid only)
//   load_i       in   capture data_i this cycle
//   unload_i     in   held sample is consumed this cycle
//   data_i       in   sample to capture
//   valid_o      out  hold register currently holds a sample
//   valid_nxt_o  out  value valid_o will take after this edge
//   data_o       out  held sample
// -----------------------------------------------------------------------------
module intpol2_d4_in_feeder_skid1 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_i,
  input  logic                  unload_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic                  valid_nxt_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Load after unload: a simultaneous load/unload replaces the held sample.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (unload_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload carries no reset; it is only observed while valid_q is set.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid_o     = valid_q;
  assign valid_nxt_o = valid_d;
  assign data_o      = data_q;

endmodule

// File: rtl/intpol2_d4_in_feeder.sv
// -----------------------------------------------------------------------------
// intpol2_d4_in_feeder
//   Writer side of the interpolator input FIFO. Streams ilen samples out of a
//   sample memory with one cycle of read latency into the FIFO, respecting the
//   FIFO almost-full flag through a one-entry hold register so no in-flight
//   sample is dropped. Supports one-shot (mode=0) and continuous wrap-around
//   (mode=1) playback.
//
// Ports
//   clk             in   clock, rising edge
//   rstn            in   asynchronous active-low reset
//   start           in   1-cycle pulse, begins a transfer when idle
//   mode            in   0 = one-shot, 1 = continuous until stop
//   stop            in   1-cycle pulse, ends a run (in-flight data delivered)
//   ilen            in   samples per pass, sampled at start
//   mem_rd          out  sample memory read strobe
//   mem_addr        out  sample memory address
//   mem_data        in   read data, valid the cycle after mem_rd
//   Afull_i         in   FIFO almost-full; no write while high
//   Write_Enable_o  out  FIFO write strobe
//   fifo_wdata      out  FIFO write data (zero when not writing)
//   busy            out  transfer in progress (cycle after start .. done)
//   done            out  1-cycle end-of-transfer pulse
// -----------------------------------------------------------------------------
module intpol2_d4_in_feeder
  import intpol2_d4_in_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_SIZE_Y = DEF_MEM_SIZE_Y
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  stop,
  input  logic [MEM_SIZE_Y:0]   ilen,
  output logic                  mem_rd,
  output logic [MEM_SIZE_Y-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  Afull_i,
  output logic                  Write_Enable_o,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = MEM_SIZE_Y + 1;

  feeder_state_e         state_q, state_d;
  logic [CW-1:0]         ilen_q, ilen_d;
  logic                  mode_q, mode_d;
  logic [MEM_SIZE_Y-1:0] addr_q, addr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  pend_q, pend_d;

  logic                  rd_issue;
  logic                  last_issue;
  logic [CW-1:0]         ilen_m1;
  logic                  hold_valid, hold_valid_nxt;
  logic                  hold_load, hold_unload;
  logic [DATA_WIDTH-1:0] hold_data;

  // ---------------------------------------------------------------------------
  // Hold register
  // ---------------------------------------------------------------------------
  intpol2_d4_in_feeder_skid1 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk         (clk),
    .rstn        (rstn),
    .load_i      (hold_load),
    .unload_i    (hold_unload),
    .data_i      (mem_data),
    .valid_o     (hold_valid),
    .valid_nxt_o (hold_valid_nxt),
    .data_o      (hold_data)
  );

  // ---------------------------------------------------------------------------
  // Read issue and write mux
  // ---------------------------------------------------------------------------
  // A read is only launched when the hold register is empty and the FIFO has
  // room, which guarantees an arriving sample never collides with a held one.
  always_comb begin
    ilen_m1    = ilen_q - CW'(1);
    rd_issue   = (state_q == ST_RUN) && !Afull_i && !hold_valid &&
                 (ilen_q != '0) && (mode_q || (count_q < ilen_q));
    last_issue = rd_issue && !mode_q && ((count_q + CW'(1)) == ilen_q);

    hold_unload = hold_valid && !Afull_i;
    hold_load   = pend_q && (hold_valid || Afull_i);

    // Held sample has write priority over the memory path.
    Write_Enable_o = hold_unload || (pend_q && !hold_valid && !Afull_i);
    fifo_wdata     = '0;
    if (Write_Enable_o) begin
      fifo_wdata = hold_valid ? hold_data : mem_data;
    end
  end

  assign mem_rd   = rd_issue;
  assign mem_addr = addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

  // ---------------------------------------------------------------------------
  // Sequencing FSM and address/count counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ilen_d  = ilen_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    count_d = count_q;
    pend_d  = rd_issue;

    if (rd_issue) begin
      // Wrap only matters in continuous mode; one-shot leaves RUN first.
      if (mode_q && ({1'b0, addr_q} == ilen_m1)) begin
        addr_d = '0;
      end else begin
        addr_d = addr_q + MEM_SIZE_Y'(1);
      end
      if (count_q != {CW{1'b1}}) begin
        count_d = count_q + CW'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          ilen_d  = ilen;
          mode_d  = mode;
          addr_d  = '0;
          count_d = '0;
        end
      end
      ST_RUN: begin
        // Zero-length pass: finish without touching memory or FIFO.
        if (ilen_q == '0) begin
          state_d = ST_DONE;
        end else if (stop || last_issue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Look at next-cycle occupancy so done follows the last write directly.
        if (!pend_d && !hold_valid_nxt) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ilen_q  <= '0;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ilen_q  <= ilen_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  // An arriving read must never find the hold register occupied.
  a_no_pend_with_hold: assert property (@(posedge clk) disable iff (!rstn)
    !(pend_q && hold_valid));

endmodule
